// File: rtl/multi_16bit_pkg.sv
// Shared constants and FSM state type for the sequential 16x16 shift-and-add multiplier.
package multi_16bit_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Datapath: captured operands, accumulator and iteration counter; one multiplier bit per step.
module mult_shift_add_dp #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic [2*WIDTH-1:0] acc,
  output logic               iter_done_c
);
  import multi_16bit_pkg::*;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  assign iter_done_c = (cnt == CNT_W'(WIDTH));

  // Load clears everything and captures operands; each step consumes one multiplier bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= (2*WIDTH)'(ain);
      mplier <= bin;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_16bit.sv
// Sequential unsigned multiplier: control FSM plus registered product and done flag.
module multi_16bit #(
  parameter int unsigned WIDTH = multi_16bit_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   ain,
  input  logic [WIDTH-1:0]   bin,
  output logic [2*WIDTH-1:0] yout,
  output logic               done
);
  import multi_16bit_pkg::*;

  state_t             state;
  state_t             state_next;
  logic               load_c;
  logic               step_c;
  logic               finish_c;
  logic               iter_done_c;
  logic [2*WIDTH-1:0] acc;

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_c),
    .step        (step_c),
    .ain         (ain),
    .bin         (bin),
    .acc         (acc),
    .iter_done_c (iter_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (iter_done_c) state_next = DONE;
      DONE:    if (start) state_next = BUSY;
      default: state_next = IDLE;
    endcase
  end

  // Start is honoured only outside BUSY; the edge after the last iteration publishes the result.
  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state)
      IDLE:    load_c   = start;
      BUSY: begin
        step_c   = !iter_done_c;
        finish_c = iter_done_c;
      end
      DONE:    load_c   = start;
      default: load_c   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yout <= '0;
      done <= 1'b0;
    end else if (load_c) begin
      done <= 1'b0;
    end else if (finish_c) begin
      yout <= acc;
      done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_16bit.sv
// Bench for multi_16bit: cycle-level reference model plus directed and random vectors.
module tb_multi_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [31:0] yout;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: a launched job reports ain*bin exactly 17 edges after the accepting edge.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_yout = '0;
  logic [31:0] m_prod = '0;

  multi_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ain   (ain),
    .bin   (bin),
    .yout  (yout),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_yout <= '0;
      m_prod <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_yout <= m_prod;
      end
    end else if (start) begin
      m_prod <= 32'(ain) * 32'(bin);
      m_left <= 17;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_done", 32'(done), 32'(m_done));
    check("model_yout", yout, m_yout);
  end

  // Pulse start for one edge, then count edges until done; checks latency and literal product.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name);
    int n;
    @(negedge clk);
    ain = a; bin = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_done_low_after_start"}, 32'(done), 32'd0);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check({name, "_latency"}, 32'(n), 32'd17);
    check({name, "_yout"}, yout, exp);
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    logic [15:0] rb;
    rst_n = 1'b0; start = 1'b0; ain = '0; bin = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_yout", yout, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_done", 32'(done), 32'd0);

    run_op(16'd3, 16'd5, 32'd15, "3x5");
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");
    run_op(16'd0, 16'h1234, 32'd0, "zero_a");
    run_op(16'h8000, 16'd2, 32'h00010000, "carry");

    // Back-to-back relaunch from DONE.
    run_op(16'd2, 16'd3, 32'd6, "b2b");

    // Start during BUSY with changed operands must be ignored.
    @(negedge clk);
    ain = 16'd100; bin = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ain = 16'd7; bin = 16'd7;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 40 && !done) begin @(negedge clk); n++; end
    check("busy_start_ignored_yout", yout, 32'd20000);
    repeat (6) @(negedge clk);
    check("done_holds", 32'(done), 32'd1);
    check("yout_holds", yout, 32'd20000);

    // Start held for several cycles in IDLE-equivalent launches only one job.
    @(negedge clk);
    ain = 16'd3; bin = 16'd4; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 40 && !done) begin @(negedge clk); n++; end
    check("held_start_yout", yout, 32'd12);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    ain = 16'd9; bin = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_done_immediate", 32'(done), 32'd0);
    check("abort_yout_immediate", yout, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_yout_stays0", yout, 32'd0);
    run_op(16'd9, 16'd9, 32'd81, "after_abort");

    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 32'(ra) * 32'(rb), "rand");
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
